// File: rtl/uart_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_bridge_pkg
// Shared constants for the UART-to-memory-bus command bridge: command and
// reply byte codes, the bridge state encoding and a byte-select helper used to
// serialise 32-bit words LSB first.
// -----------------------------------------------------------------------------
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        MEM  = 3'd3,
        SEND = 3'd4,
        WAIT = 3'd5
    } state_e;

    // Select byte idx (0 = least significant) of a 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_mem_bridge.sv
// -----------------------------------------------------------------------------
// uart_mem_bridge
// Host command responder between the UART byte interface and the SoC memory
// bus. Received bytes are decoded as 'W' addr[4] data[4] (bus write, reply 'K')
// or 'R' addr[4] (bus read, reply rdata as 4 bytes, LSB first); any other
// command byte is answered with '?'. A stalled partial command is abandoned
// after TIMEOUT_CLK idle cycles and flagged on err_timeout.
//
// Ports
//   clk, reset           system clock / asynchronous active-high reset
//   rx_ready, rx_data    received-byte strobe and byte
//   tx_write, tx_data    transmit-start strobe and byte (held until tx_finished)
//   tx_finished          UART has finished the current byte
//   mem_req/we/addr/wdata   bus request, held until mem_ack
//   mem_rdata, mem_ack   bus read data and completion
//   busy                 bridge is not idle
//   err_timeout          one-cycle pulse when a partial command is aborted
// -----------------------------------------------------------------------------
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLK_FREQ    = 12000000,
    parameter int TIMEOUT_CLK = CLK_FREQ / 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_write,
    output logic [7:0]  tx_data,
    input  logic        tx_finished,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err_timeout
);

    localparam int            TW       = $clog2(TIMEOUT_CLK + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLK - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    state_e        state_r;
    state_e        state_s;
    logic [1:0]    fld_cnt_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [31:0]   rsp_word_r;
    logic          is_write_r;
    logic [1:0]    rsp_idx_r;
    logic [1:0]    rsp_last_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          tx_write_r;
    logic [7:0]    tx_data_r;
    logic          mem_req_r;
    logic          busy_r;
    logic          err_timeout_r;

    logic          in_field_s;
    logic          tmo_hit_s;
    logic          is_cmd_s;
    logic          ack_s;

    // Decode helpers: field states, timeout expiry (an arriving byte wins), bus completion.
    always_comb begin
        in_field_s = (state_r == ADDR) || (state_r == DATA);
        tmo_hit_s  = in_field_s && !rx_ready && (tmo_cnt_r == TMO_LAST);
        is_cmd_s   = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
        ack_s      = mem_req_r && mem_ack;
    end

    // Next-state logic of the command FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_ready) begin
                    if (is_cmd_s) begin
                        state_s = ADDR;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (rx_ready) begin
                    if (fld_cnt_r == 2'd3) begin
                        state_s = is_write_r ? DATA : MEM;
                    end else begin
                        state_s = ADDR;
                    end
                end else if (tmo_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (rx_ready) begin
                    if (fld_cnt_r == 2'd3) begin
                        state_s = MEM;
                    end else begin
                        state_s = DATA;
                    end
                end else if (tmo_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            MEM: begin
                if (ack_s) begin
                    state_s = SEND;
                end else begin
                    state_s = MEM;
                end
            end
            SEND: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (tx_finished) begin
                    if (rsp_idx_r == rsp_last_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Inter-byte gap counter: runs only while a command field is being collected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (rx_ready || !in_field_s || tmo_hit_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
    end

    // Command capture: command type, then address/data bytes shifted in LSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fld_cnt_r  <= 2'd0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            is_write_r <= 1'b0;
        end else if (state_r == IDLE) begin
            fld_cnt_r <= 2'd0;
            if (rx_ready) begin
                is_write_r <= (rx_data == CMD_WRITE);
            end
        end else if (in_field_s && rx_ready) begin
            // The 2-bit counter wraps 3->0 as the fourth byte of a field lands.
            if (state_r == ADDR) begin
                addr_r[{fld_cnt_r, 3'b000} +: 8] <= rx_data;
            end else begin
                wdata_r[{fld_cnt_r, 3'b000} +: 8] <= rx_data;
            end
            fld_cnt_r <= fld_cnt_r + 2'd1;
        end else if (tmo_hit_s) begin
            fld_cnt_r <= 2'd0;
        end
    end

    // Reply sequencing: load the byte to send each time the FSM enters SEND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data_r  <= 8'h00;
            rsp_word_r <= 32'h0000_0000;
            rsp_idx_r  <= 2'd0;
            rsp_last_r <= 2'd0;
        end else if (state_s == SEND) begin
            case (state_r)
                IDLE: begin
                    tx_data_r  <= RSP_ERR;
                    rsp_idx_r  <= 2'd0;
                    rsp_last_r <= 2'd0;
                end
                MEM: begin
                    rsp_idx_r <= 2'd0;
                    if (is_write_r) begin
                        tx_data_r  <= RSP_OK;
                        rsp_last_r <= 2'd0;
                    end else begin
                        // Read data is captured only in the acknowledge cycle.
                        rsp_word_r <= mem_rdata;
                        tx_data_r  <= byte_of(mem_rdata, 2'd0);
                        rsp_last_r <= 2'd3;
                    end
                end
                WAIT: begin
                    rsp_idx_r <= rsp_idx_r + 2'd1;
                    tx_data_r <= byte_of(rsp_word_r, rsp_idx_r + 2'd1);
                end
                default: begin
                    tx_data_r <= tx_data_r;
                end
            endcase
        end
    end

    // Registered strobes and status, derived from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_write_r    <= 1'b0;
            mem_req_r     <= 1'b0;
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            tx_write_r    <= (state_s == SEND);
            mem_req_r     <= (state_s == MEM);
            busy_r        <= (state_s != IDLE);
            err_timeout_r <= tmo_hit_s;
        end
    end

    assign tx_write    = tx_write_r;
    assign tx_data     = tx_data_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = is_write_r;
    assign mem_addr    = addr_r;
    assign mem_wdata   = wdata_r;
    assign busy        = busy_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_mem_bridge.sv
`timescale 1ns/1ps
module tb_uart_mem_bridge;

    localparam int TMO = 200;

    typedef logic [7:0] byteq_t[$];
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        tx_finished;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        err_timeout;

    uart_mem_bridge #(.CLK_FREQ(12000000), .TIMEOUT_CLK(TMO)) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_write(tx_write), .tx_data(tx_data), .tx_finished(tx_finished),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    bus_t        bus_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] bfm_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int ack_delay  = 2;
    int tx_delay   = 2;
    int bus_err    = 0;
    int tx_err     = 0;
    int tmo_pulses = 0;
    int checks     = 0;
    int failures   = 0;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    // Memory responder: records each request, acks after ack_delay cycles.
    initial begin : mem_bfm
        logic [31:0] a0;
        bit ab;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && reset === 1'b0) begin
                bus_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
                a0 = mem_addr;
                ab = 1'b0;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    if (reset) begin ab = 1'b1; break; end
                    if (mem_req !== 1'b1 || mem_addr !== a0) bus_err++;
                end
                if (!ab) begin
                    if (mem_we) bfm_mem[a0] = mem_wdata;
                    mem_rdata = bfm_mem.exists(a0) ? bfm_mem[a0] : fill(a0);
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                    // Request must be gone and the first reply byte starting.
                    if (tx_write !== 1'b1 || mem_req !== 1'b0) bus_err++;
                end
            end
        end
    end

    // UART transmitter stand-in: records bytes, finishes after tx_delay cycles.
    initial begin : tx_bfm
        logic [7:0] d0;
        tx_finished = 1'b0;
        forever begin
            @(negedge clk);
            tx_finished = 1'b0;
            if (tx_write === 1'b1 && reset === 1'b0) begin
                tx_q.push_back(tx_data);
                d0 = tx_data;
                for (int i = 0; i < tx_delay; i++) begin
                    @(negedge clk);
                    if (tx_data !== d0 || tx_write !== 1'b0) tx_err++;
                end
                tx_finished = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (err_timeout === 1'b1) tmo_pulses++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (busy === 1'b0) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic run_cmd(input byteq_t c, input int maxgap, output bit to);
        for (int i = 0; i < c.size(); i++)
            send_byte(c[i], (i == c.size() - 1) ? 0 : int'($urandom_range(0, maxgap)));
        wait_idle(to);
    endtask

    // Reference: decode a command at the protocol level.
    task automatic model_cmd(input byteq_t c, output bit hb, output bus_t eb, output byteq_t et);
        logic [31:0] a;
        logic [31:0] d;
        et = {};
        hb = 1'b0;
        eb = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
        if (c[0] == 8'h57) begin
            a = {c[4], c[3], c[2], c[1]};
            d = {c[8], c[7], c[6], c[5]};
            ref_mem[a] = d;
            hb = 1'b1;
            eb = '{we: 1'b1, addr: a, wdata: d};
            et.push_back(8'h4B);
        end else if (c[0] == 8'h52) begin
            a = {c[4], c[3], c[2], c[1]};
            d = ref_mem.exists(a) ? ref_mem[a] : fill(a);
            hb = 1'b1;
            eb = '{we: 1'b0, addr: a, wdata: 32'h0};
            for (int k = 0; k < 4; k++) et.push_back(d[8*k +: 8]);
        end else begin
            et.push_back(8'h3F);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_write, tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err_timeout} !== 77'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {tx_write, tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err_timeout});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got=busy%b req%b exp=0 0", busy, mem_req);
        end
    endtask

    task automatic test_write();
        byteq_t c;
        bit to;
        int e0;
        int t0;
        e0 = bus_err; t0 = tx_err;
        bus_q.delete(); tx_q.delete();
        ack_delay = 3; tx_delay = 4;
        c = {8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ref_mem[32'h10] = 32'hDEADBEEF;
        for (int i = 0; i < c.size(); i++) send_byte(c[i], (i == c.size() - 1) ? 0 : 1);
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL write_req_latency got=%b exp=1", mem_req); end
        wait_idle(to);
        checks++;
        if (to) begin failures++; $display("FAIL write_idle got=busy exp=idle"); end
        checks++;
        if (bus_q.size() != 1) begin
            failures++; $display("FAIL write_bus_count got=%0d exp=1", bus_q.size());
        end else begin
            checks++;
            if (bus_q[0].we !== 1'b1 || bus_q[0].addr !== 32'h10 || bus_q[0].wdata !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL write_bus got=we%b %h %h exp=we1 00000010 deadbeef",
                         bus_q[0].we, bus_q[0].addr, bus_q[0].wdata);
            end
        end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
            failures++; $display("FAIL write_reply got=%p exp='{4b}", tx_q);
        end
        checks++;
        if (bus_err != e0 || tx_err != t0) begin
            failures++; $display("FAIL write_handshake got=%0d/%0d exp=%0d/%0d", bus_err, tx_err, e0, t0);
        end
    endtask

    task automatic test_read();
        byteq_t c;
        bit to;
        int t0;
        t0 = tx_err;
        bus_q.delete(); tx_q.delete();
        bfm_mem[32'h4] = 32'h12345678;
        ref_mem[32'h4] = 32'h12345678;
        ack_delay = 2; tx_delay = 3;
        c = {8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
        run_cmd(c, 2, to);
        checks++;
        if (to || bus_q.size() != 1) begin
            failures++; $display("FAIL read_bus_count got=%0d exp=1", bus_q.size());
        end else begin
            checks++;
            if (bus_q[0].we !== 1'b0 || bus_q[0].addr !== 32'h4) begin
                failures++; $display("FAIL read_bus got=we%b %h exp=we0 00000004", bus_q[0].we, bus_q[0].addr);
            end
        end
        checks++;
        if (tx_q.size() != 4 || tx_q[0] !== 8'h78 || tx_q[1] !== 8'h56 || tx_q[2] !== 8'h34 || tx_q[3] !== 8'h12) begin
            failures++; $display("FAIL read_reply got=%p exp='{78,56,34,12}", tx_q);
        end
        checks++;
        if (tx_err != t0) begin failures++; $display("FAIL read_tx_stable got=%0d exp=%0d", tx_err, t0); end
    endtask

    task automatic test_unknown();
        byteq_t c;
        bit to;
        bus_q.delete(); tx_q.delete();
        c = {8'h41};
        run_cmd(c, 0, to);
        checks++;
        if (to || tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin
            failures++; $display("FAIL unknown_reply got=%p exp='{3f}", tx_q);
        end
        checks++;
        if (bus_q.size() != 0) begin failures++; $display("FAIL unknown_bus got=%0d exp=0", bus_q.size()); end
    endtask

    task automatic test_timeout();
        byteq_t c;
        byteq_t et;
        bus_t eb;
        bit hb;
        bit to;
        int seen;
        int p0;
        bus_q.delete(); tx_q.delete();
        p0 = tmo_pulses;
        send_byte(8'h57, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        seen = 0;
        for (int i = 1; i <= 2 * TMO; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin seen = i; break; end
        end
        checks++;
        if (seen < TMO - 1 || seen > TMO + 1) begin
            failures++; $display("FAIL timeout_time got=%0d exp=%0d", seen, TMO);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle got=%b exp=0", busy); end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || tmo_pulses != p0 + 1) begin
            failures++; $display("FAIL timeout_pulse got=%0d exp=%0d", tmo_pulses - p0, 1);
        end
        c = {8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
        model_cmd(c, hb, eb, et);
        run_cmd(c, 1, to);
        checks++;
        if (to || bus_q.size() != 1 || tx_q != et) begin
            failures++; $display("FAIL timeout_recover got=%p exp=%p", tx_q, et);
        end
        // A byte landing exactly in the expiry cycle must still be taken.
        bus_q.delete(); tx_q.delete();
        p0 = tmo_pulses;
        c = {8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        model_cmd(c, hb, eb, et);
        send_byte(c[0], TMO - 1);
        for (int i = 1; i < 5; i++) send_byte(c[i], 0);
        wait_idle(to);
        checks++;
        if (to || tmo_pulses != p0 || bus_q.size() != 1 || tx_q != et) begin
            failures++; $display("FAIL timeout_byte_wins got=pulses%0d %p exp=pulses0 %p", tmo_pulses - p0, tx_q, et);
        end
    endtask

    task automatic test_stall_drop();
        byteq_t c;
        byteq_t et;
        bus_t eb;
        bit hb;
        bit to;
        int e0;
        e0 = bus_err;
        bus_q.delete(); tx_q.delete();
        ack_delay = 1000; tx_delay = 2;
        c = {8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
        model_cmd(c, hb, eb, et);
        for (int i = 0; i < 5; i++) send_byte(c[i], 0);
        repeat (10) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
            failures++; $display("FAIL stall_req got=%b %h exp=1 00000020", mem_req, mem_addr);
        end
        send_byte(8'h52, 0);
        wait_idle(to);
        repeat (20) @(negedge clk);
        checks++;
        if (to || bus_q.size() != 1 || bus_err != e0) begin
            failures++; $display("FAIL stall_bus got=%0d err%0d exp=1 err%0d", bus_q.size(), bus_err, e0);
        end
        checks++;
        if (tx_q != et) begin failures++; $display("FAIL stall_reply got=%p exp=%p", tx_q, et); end
        ack_delay = 2;
    endtask

    task automatic test_reset_midop();
        byteq_t c;
        byteq_t et;
        bus_t eb;
        bit hb;
        bit to;
        logic [31:0] a;
        logic [31:0] d;
        ack_delay = 50;
        c = {8'h52, 8'h30, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) send_byte(c[i], 0);
        repeat (5) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || tx_write !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_async got=%b%b%b exp=000", mem_req, tx_write, busy);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_q.delete(); tx_q.delete();
        ack_delay = 2;
        a = $urandom; d = $urandom;
        c = {8'h57};
        for (int k = 0; k < 4; k++) c.push_back(a[8*k +: 8]);
        for (int k = 0; k < 4; k++) c.push_back(d[8*k +: 8]);
        model_cmd(c, hb, eb, et);
        run_cmd(c, 2, to);
        checks++;
        if (to || bus_q.size() != 1 || tx_q != et) begin
            failures++; $display("FAIL rst_after_cmd got=%p n%0d exp=%p n1", tx_q, bus_q.size(), et);
        end else begin
            checks++;
            if (bus_q[0].we !== 1'b1 || bus_q[0].addr !== a || bus_q[0].wdata !== d) begin
                failures++; $display("FAIL rst_after_bus got=%h %h exp=%h %h", bus_q[0].addr, bus_q[0].wdata, a, d);
            end
        end
    endtask

    task automatic test_random();
        byteq_t c;
        byteq_t et;
        bus_t eb;
        bit hb;
        bit to;
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0] b;
        int kind;
        int e0;
        int t0;
        int p0;
        e0 = bus_err; t0 = tx_err; p0 = tmo_pulses;
        for (int n = 0; n < 30; n++) begin
            bus_q.delete(); tx_q.delete();
            ack_delay = int'($urandom_range(0, 5));
            tx_delay = int'($urandom_range(1, 4));
            kind = int'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 7)) * 32'd4;
            d = $urandom;
            if (kind == 0) begin
                c = {8'h57};
                for (int k = 0; k < 4; k++) c.push_back(a[8*k +: 8]);
                for (int k = 0; k < 4; k++) c.push_back(d[8*k +: 8]);
            end else if (kind == 1) begin
                c = {8'h52};
                for (int k = 0; k < 4; k++) c.push_back(a[8*k +: 8]);
            end else begin
                b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                c = {b};
            end
            model_cmd(c, hb, eb, et);
            run_cmd(c, 3, to);
            checks++;
            if (to || bus_q.size() != (hb ? 1 : 0)) begin
                failures++; $display("FAIL rnd_bus_count cmd=%0d got=%0d exp=%0d", n, bus_q.size(), hb ? 1 : 0);
            end else if (hb) begin
                checks++;
                if (bus_q[0].we !== eb.we || bus_q[0].addr !== eb.addr || (eb.we && bus_q[0].wdata !== eb.wdata)) begin
                    failures++;
                    $display("FAIL rnd_bus cmd=%0d got=we%b %h %h exp=we%b %h %h", n,
                             bus_q[0].we, bus_q[0].addr, bus_q[0].wdata, eb.we, eb.addr, eb.wdata);
                end
            end
            checks++;
            if (tx_q.size() != et.size()) begin
                failures++; $display("FAIL rnd_tx_count cmd=%0d got=%0d exp=%0d", n, tx_q.size(), et.size());
            end else begin
                for (int k = 0; k < et.size(); k++) begin
                    checks++;
                    if (tx_q[k] !== et[k]) begin
                        failures++; $display("FAIL rnd_tx cmd=%0d byte=%0d got=%h exp=%h", n, k, tx_q[k], et[k]);
                    end
                end
            end
        end
        checks++;
        if (bus_err != e0 || tx_err != t0 || tmo_pulses != p0) begin
            failures++;
            $display("FAIL rnd_protocol got=bus%0d tx%0d tmo%0d exp=0 0 0", bus_err - e0, tx_err - t0, tmo_pulses - p0);
        end
    endtask

    task automatic test_back_to_back();
        byteq_t c;
        byteq_t et;
        bus_t eb;
        bit hb;
        bit to;
        ack_delay = 1; tx_delay = 1;
        bus_q.delete(); tx_q.delete();
        c = {8'h41};
        run_cmd(c, 0, to);
        tx_q.delete();
        // wait_idle returns in the first IDLE cycle; the next byte goes in right there.
        c = {8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        model_cmd(c, hb, eb, et);
        run_cmd(c, 0, to);
        checks++;
        if (to || bus_q.size() != 1 || tx_q != et) begin
            failures++; $display("FAIL b2b_read got=%p exp=%p", tx_q, et);
        end
        bus_q.delete(); tx_q.delete();
        c = {8'h3A};
        run_cmd(c, 0, to);
        checks++;
        if (to || bus_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin
            failures++; $display("FAIL b2b_unknown got=%p exp='{3f}", tx_q);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unknown();
        test_timeout();
        test_stall_drop();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
